// File: rtl/mips_hazard_pkg.sv
// Shared types for the MIPS hazard/forwarding logic and the EX operand muxes.
package mips_hazard_pkg;

  // EX-stage operand mux select
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Hazard controller state
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LD_STALL = 2'b01,
    MDU_WAIT = 2'b10
  } hz_state_t;

  localparam int unsigned REG_ZERO = 0;

  // The newer producer (EX, arriving in MEM next cycle) beats the older one.
  function automatic fwd_sel_t fwd_pick(input logic ex_hit, input logic mem_hit);
    if (ex_hit) return FWD_MEM;
    if (mem_hit) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_mdu_timer.sv
// HI/LO occupancy counter: loads on start, counts down, saturates at zero.
module hazard_mdu_timer #(
  parameter int unsigned LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  localparam int unsigned CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  // The op's first EX cycle overlaps the dependent instruction's first ID
  // cycle, so only LATENCY-1 cycles of ID-side blocking remain.
  localparam logic [CW-1:0] LOAD = CW'(LATENCY - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: reload on start, otherwise decrement toward zero
  always_comb begin
    count_d = count_q;
    if (start)               count_d = LOAD;
    else if (count_q != '0)  count_d = count_q - CW'(1);
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign busy = (count_q != '0);

endmodule

// File: rtl/hazard_forward_unit.sv
// ID-stage hazard detection and forwarding control for the 5-stage pipeline.
// Optional HI/LO interlock enabled by defining HAZARD_MDU_INTERLOCK_EN.
module hazard_forward_unit
  import mips_hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MDU_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rt,
  input  logic              id_use_hilo,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              mdu_start,
  input  logic              flush,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall_if_id,
  output logic              bubble_ex
);

  localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

  hz_state_t   state_q, state_d;
  fwd_sel_t    fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  fwd_sel_t    sel_a, sel_b;
  logic        load_use, hilo_hz, stall;
  logic        mdu_busy;
  logic [REG_AW-1:0] src_b;

`ifdef HAZARD_MDU_INTERLOCK_EN
  hazard_mdu_timer #(.LATENCY(MDU_LATENCY)) u_mdu_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mdu_start && !flush),
    .busy  (mdu_busy)
  );
  assign hilo_hz = id_use_hilo && mdu_busy;
`else
  logic unused_mdu_inputs;
  assign unused_mdu_inputs = mdu_start ^ id_use_hilo ^ (MDU_LATENCY == 0);
  assign mdu_busy = 1'b0;
  assign hilo_hz  = 1'b0;
`endif

  // Operand selects and hazard detection from the current ID/EX/MEM view
  always_comb begin
    src_b    = id_use_rt ? id_rt : ZERO;
    sel_a    = fwd_pick(ex_regwrite  && ex_rd  == id_rs && id_rs != ZERO,
                        mem_regwrite && mem_rd == id_rs && id_rs != ZERO);
    sel_b    = fwd_pick(ex_regwrite  && ex_rd  == src_b && src_b != ZERO,
                        mem_regwrite && mem_rd == src_b && src_b != ZERO);
    load_use = ex_memread && ex_rd != ZERO &&
               (ex_rd == id_rs || (id_use_rt && ex_rd == id_rt));
    // flush kills the ID instruction, so it can never be stalled; reset
    // forces the controls low immediately
    stall    = (load_use || hilo_hz) && !flush && rst_n;
    fwd_a_d  = (stall || flush) ? FWD_REG : sel_a;
    fwd_b_d  = (stall || flush) ? FWD_REG : sel_b;
  end

  // Next-state logic for the stall controller
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (stall) state_d = load_use ? LD_STALL : MDU_WAIT;
      end
      LD_STALL: begin
        state_d = (hilo_hz && !flush) ? MDU_WAIT : RUN;
      end
`ifdef HAZARD_MDU_INTERLOCK_EN
      MDU_WAIT: begin
        if (!mdu_busy) state_d = RUN;
      end
`endif
      default: state_d = RUN;
    endcase
  end

  // State and ID->EX forward-select registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      state_q <= state_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign forward_a   = fwd_a_q;
  assign forward_b   = fwd_b_q;
  assign stall_if_id = stall;
  assign bubble_ex   = stall;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed cases then random traffic
// against a behavioural model of the forwarding/stall rules.
module tb_hazard_forward_unit;

  localparam int unsigned AW  = 5;
  localparam int unsigned LAT = 4;
`ifdef HAZARD_MDU_INTERLOCK_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] id_rs, id_rt, ex_rd, mem_rd;
  logic          id_use_rt, id_use_hilo, ex_regwrite, ex_memread, mem_regwrite;
  logic          mdu_start, flush;
  logic [1:0]    forward_a, forward_b;
  logic          stall_if_id, bubble_ex;

  int n_tests = 0;
  int n_fail  = 0;
  int mdu_left = 0;   // model: cycles the ID stage must still wait for HI/LO

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_AW(AW), .MDU_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rt(id_use_rt), .id_use_hilo(id_use_hilo), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mdu_start(mdu_start), .flush(flush),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall_if_id(stall_if_id), .bubble_ex(bubble_ex)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Model: where will this source's value be next cycle?
  function automatic int unsigned ref_sel(input int unsigned src, input bit used);
    if (!used || src == 0) return 0;
    if (ex_regwrite && ex_rd == src) return 2;   // EX producer moves to MEM
    if (mem_regwrite && mem_rd == src) return 1; // MEM producer moves to WB
    return 0;
  endfunction

  function automatic bit ref_stall();
    bit lu, hl;
    lu = ex_memread && ex_rd != 0 && (ex_rd == id_rs || (id_use_rt && ex_rd == id_rt));
    hl = MDU_EN && id_use_hilo && mdu_left > 0;
    return (lu || hl) && !flush;
  endfunction

  task automatic idle();
    id_rs = '0; id_rt = '0; id_use_rt = 0; id_use_hilo = 0;
    ex_rd = '0; ex_regwrite = 0; ex_memread = 0;
    mem_rd = '0; mem_regwrite = 0; mdu_start = 0; flush = 0;
  endtask

  // One clock: check combinational controls mid-cycle, then the registered
  // selects just after the edge. Inputs must be set before calling.
  task automatic cycle(input string tag, output logic st);
    bit          es;
    int unsigned ea, eb;
    @(negedge clk);
    es = ref_stall();
    st = stall_if_id;
    check({tag, "_stall"},  stall_if_id, es);
    check({tag, "_bubble"}, bubble_ex,   es);
    ea = (es || flush) ? 0 : ref_sel(id_rs, 1'b1);
    eb = (es || flush) ? 0 : ref_sel(id_rt, id_use_rt);
    if (MDU_EN && mdu_start && !flush) mdu_left = LAT - 1;
    else if (mdu_left > 0)             mdu_left--;
    @(posedge clk); #1;
    check({tag, "_fa"}, forward_a, ea);
    check({tag, "_fb"}, forward_b, eb);
  endtask

  initial begin
    logic st;
    int   nst;
    idle();
    rst_n = 1'b0;
    #1;
    check("rst_fa", forward_a, 0);
    check("rst_fb", forward_b, 0);
    check("rst_stall", stall_if_id, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU forward, then with an older MEM producer of the same register
    ex_rd = 8; ex_regwrite = 1; id_rs = 8;
    cycle("alu", st);  check("alu_fa_const", forward_a, 2);
    mem_rd = 8; mem_regwrite = 1;
    cycle("alu_mem", st); check("alu_mem_fa_const", forward_a, 2);

    // WB forward on rt; $0 never forwards
    idle(); mem_rd = 9; mem_regwrite = 1; id_rt = 9; id_use_rt = 1;
    cycle("wb", st);  check("wb_fb_const", forward_b, 1);
    mem_rd = 0; id_rt = 0;
    cycle("wb0", st); check("wb0_fb_const", forward_b, 0);

    // Load-use: one stall cycle, then the load in MEM forwards from WB
    idle(); ex_memread = 1; ex_regwrite = 1; ex_rd = 4; id_rs = 4;
    cycle("ld", st);  check("ld_stall_const", st, 1); check("ld_fa_const", forward_a, 0);
    idle(); mem_rd = 4; mem_regwrite = 1; id_rs = 4;
    cycle("ld2", st); check("ld2_stall_const", st, 0); check("ld2_fa_const", forward_a, 1);

    // MDU: start, then mfhi the next cycle; count stall cycles (bounded)
    idle(); mdu_start = 1;
    cycle("mdu_go", st);
    mdu_start = 0; id_use_hilo = 1; nst = 0;
    for (int i = 0; i < 10; i++) begin
      cycle("mdu", st);
      if (st) nst++; else break;
    end
    check("mdu_stall_cycles", nst, MDU_EN ? LAT - 1 : 0);

    // Flush beats a load-use hazard
    idle(); ex_memread = 1; ex_regwrite = 1; ex_rd = 6; id_rs = 6; flush = 1;
    cycle("flush", st); check("flush_stall_const", st, 0); check("flush_fa_const", forward_a, 0);

    // Async reset mid-cycle while a stall is active and a select is nonzero
    idle(); ex_rd = 3; ex_regwrite = 1; id_rs = 3;
    cycle("pre_rst", st);
    ex_memread = 1;
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_fa", forward_a, 0);
    check("mid_rst_stall", stall_if_id, 0);
    mdu_left = 0;
    @(negedge clk); rst_n = 1'b1; idle();
    @(posedge clk); #1;

    // Random traffic over a small register set to force collisions
    for (int i = 0; i < 400; i++) begin
      id_rs        = AW'($urandom_range(0, 3));
      id_rt        = AW'($urandom_range(0, 3));
      ex_rd        = AW'($urandom_range(0, 3));
      mem_rd       = AW'($urandom_range(0, 3));
      id_use_rt    = 1'($urandom_range(0, 1));
      ex_regwrite  = 1'($urandom_range(0, 1));
      ex_memread   = ex_regwrite && ($urandom_range(0, 2) == 0);
      mem_regwrite = 1'($urandom_range(0, 1));
      id_use_hilo  = ($urandom_range(0, 2) == 0);
      mdu_start    = ($urandom_range(0, 7) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      cycle("rnd", st);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
